// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : PC generation / instruction fetch with a one-entry decode buffer
//            and branch-redirect squashing of in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_KILL_REQ  = 3'd3,
        S_KILL_WAIT = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_inst, w_if_inst_nxt;
    logic [31:0] w_target;
    logic        w_issue;
    logic        w_accept;

    assign w_target       = redirect_target & ~32'd3;
    assign w_issue        = (r_state == S_REQ) && (!r_if_valid || if_ready);
    // A killed request keeps presenting its original (stale) address.
    assign imem_req_valid = w_issue || (r_state == S_KILL_REQ);
    assign imem_req_addr  = (r_state == S_KILL_REQ) ? r_fetch_pc : r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_inst_nxt  = r_if_inst;

        if (r_if_valid && if_ready) begin
            w_if_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_accept) begin
                    w_state_nxt    = S_WAIT;
                    w_fetch_pc_nxt = r_pc;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = S_REQ;
                    if (!redirect_valid) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_pc_nxt    = r_fetch_pc;
                        w_if_inst_nxt  = imem_resp_data;
                        w_pc_nxt       = r_pc + 32'd4;
                    end
                end
            end
            S_KILL_REQ: begin
                if (w_accept) begin
                    w_state_nxt = S_KILL_WAIT;
                end
            end
            S_KILL_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Redirect overrides buffer and PC; kill states keep tracking their
        // outstanding request so only one is ever in flight.
        if (redirect_valid) begin
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (w_accept) begin
                        w_state_nxt = S_KILL_WAIT;
                    end else begin
                        w_state_nxt    = S_KILL_REQ;
                        w_fetch_pc_nxt = r_pc;
                    end
                end
                S_WAIT: w_state_nxt = imem_resp_valid ? S_REQ : S_KILL_WAIT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_fetch_pc <= 32'd0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_inst  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Self-checking bench for ifu_fetch: directed reset/stall/wrap
//            cases plus randomized traffic against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    ifu_fetch #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pops     = 0;
    // stimulus knobs
    bit          rand_mode = 1'b0;
    int          max_lat   = 0;
    logic        drv_if_ready = 1'b0;
    logic        drv_req_ready = 1'b0;
    logic        drv_redir = 1'b0;
    logic [31:0] drv_target = 32'd0;
    // reference model
    logic [31:0] exp_pc;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          prev_req_pend;
    logic [31:0] prev_req_addr;
    bit          prev_stall;
    logic [31:0] prev_if_pc;
    logic [31:0] prev_if_inst;
    bit          acc_last;
    int          pop_cyc[$];
    logic [31:0] acc_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic reset_model();
        mem_busy      = 1'b0;
        mem_cnt       = 0;
        mem_addr      = 32'd0;
        prev_req_pend = 1'b0;
        prev_stall    = 1'b0;
        acc_last      = 1'b0;
        exp_pc        = C_RESET_PC;
    endtask

    task automatic observe();
        if (!rst_n) return;
        if (prev_req_pend) begin
            check_eq("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            check_eq("req_hold_addr", imem_req_addr, prev_req_addr);
        end
        if (prev_stall) begin
            check_eq("if_hold_valid", {31'd0, if_valid}, 32'd1);
            check_eq("if_hold_pc", if_pc, prev_if_pc);
            check_eq("if_hold_inst", if_inst, prev_if_inst);
        end
        // Architectural stream: every delivered entry follows the PC sequence.
        if (redirect_valid) begin
            exp_pc = redirect_target & ~32'd3;
        end else if (if_valid && if_ready) begin
            check_eq("pop_pc", if_pc, exp_pc);
            check_eq("pop_inst", if_inst, memfn(if_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (imem_resp_valid) mem_busy = 1'b0;
        acc_last = imem_req_valid && imem_req_ready;
        if (acc_last) begin
            check_eq("one_outstanding", {31'd0, mem_busy}, 32'd0);
            check_eq("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom_range(0, max_lat);
            acc_q.push_back(imem_req_addr);
        end
        prev_req_pend = imem_req_valid && !imem_req_ready;
        prev_req_addr = imem_req_addr;
        prev_stall    = if_valid && !if_ready && !redirect_valid;
        prev_if_pc    = if_pc;
        prev_if_inst  = if_inst;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_busy && mem_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memfn(mem_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (mem_busy) mem_cnt--;
        end
        if (rand_mode) begin
            if_ready        = ($urandom_range(0, 3) != 0);
            imem_req_ready  = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 11) == 0);
            redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
        end else begin
            if_ready        = drv_if_ready;
            imem_req_ready  = drv_req_ready;
            redirect_valid  = drv_redir;
            redirect_target = drv_target;
        end
        @(negedge clk);
        observe();
    endtask

    initial begin
        bit found;
        reset_model();
        repeat (2) cycle();
        check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Zero-wait memory, decode always ready.
        drv_if_ready  = 1'b1;
        drv_req_ready = 1'b1;
        rst_n = 1'b1;
        reset_model();
        cyc = 0;
        pop_cyc.delete();
        #1;
        check_eq("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check_eq("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("first_req_addr", imem_req_addr, C_RESET_PC);
        repeat (6) cycle();
        check_eq("t1_pops", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() >= 3) begin
            check_eq("t1_first_pop_cyc", pop_cyc[0], 32'd3);
            check_eq("t1_gap_a", pop_cyc[1] - pop_cyc[0], 32'd2);
            check_eq("t1_gap_b", pop_cyc[2] - pop_cyc[1], 32'd2);
        end

        // Decode stall: buffer holds, no new request until the pop.
        drv_if_ready = 1'b0;
        repeat (4) cycle();
        check_eq("t2_buf_valid", {31'd0, if_valid}, 32'd1);
        check_eq("t2_buf_pc", if_pc, 32'h8000_000C);
        repeat (3) begin
            check_eq("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
            cycle();
        end
        drv_if_ready = 1'b1;
        cycle();
        check_eq("t2_req_on_pop", {31'd0, imem_req_valid}, 32'd1);
        check_eq("t2_req_addr", imem_req_addr, 32'h8000_0010);

        // Redirect to the top word; fetch must wrap to address 0.
        acc_q.delete();
        drv_redir  = 1'b1;
        drv_target = 32'hFFFF_FFFE;
        cycle();
        drv_redir = 1'b0;
        repeat (12) cycle();
        found = 1'b0;
        for (int i = 0; i + 1 < acc_q.size(); i++) begin
            if (!found && acc_q[i] == 32'hFFFF_FFFC) begin
                found = 1'b1;
                check_eq("t6_wrap_addr", acc_q[i + 1], 32'd0);
            end
        end
        check_eq("t6_wrap_seen", {31'd0, found}, 32'd1);

        // Asynchronous reset while a slow response is outstanding.
        max_lat = 3;
        for (int i = 0; i < 20 && !acc_last; i++) cycle();
        check_eq("t6_accept_seen", {31'd0, acc_last}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check_eq("arst_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("arst_if_pc", if_pc, 32'd0);
        check_eq("arst_if_inst", if_inst, 32'd0);
        check_eq("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Randomized traffic with redirects, stalls and variable latency.
        rand_mode = 1'b1;
        pops = 0;
        repeat (4000) cycle();
        check_eq("liveness_pops", {31'd0, pops > 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
